// File: rtl/event_tone_player.sv
// Event-to-tone generator: any edge on an event level plays a square-wave tone
// for `duration_i` cycles at that event's programmed half-period.
// Optional macro SOUND_DOUBLE_BEEP_EN adds a silent gap and a second beep
// after each tone.
module event_tone_player #(
    parameter int unsigned N_EVENTS = 4,
    parameter int unsigned DIV_W    = 18,
    parameter int unsigned DUR_W    = 27,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [N_EVENTS-1:0]       ev_level_i,
    input  logic [N_EVENTS*DIV_W-1:0] half_period_i,
    input  logic [DUR_W-1:0]          duration_i,
    output logic                      speaker_o,
    output logic                      busy_o,
    output logic [IDX_W-1:0]          active_ev_o
);

`ifdef SOUND_DOUBLE_BEEP_EN
    typedef enum logic [1:0] {StIdle, StPlay, StGap, StPlay2} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPlay} state_e;
`endif

    state_e               state_q, state_d;
    logic [N_EVENTS-1:0]  sync1_q, sync2_q, prev_q;
    logic [1:0]           warm_q;
    logic [DIV_W-1:0]     hp_q, hp_d;
    logic [DIV_W-1:0]     tone_q, tone_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic                 spk_q, spk_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [N_EVENTS-1:0]  change;
    logic                 trig;
    logic [IDX_W-1:0]     trig_idx;
    logic [DIV_W-1:0]     trig_hp;
    logic [DUR_W:0]       dur_p1;
    logic                 dur_end;
    logic [DUR_W-1:0]     dur_inc;
    logic [DIV_W-1:0]     tone_nxt;
    logic                 spk_nxt;

    // Input synchroniser, edge-detect history and post-reset warm-up counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= ev_level_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
        end
    end

    // Edge detect, gated off until the synchroniser has settled after reset.
    assign change = (warm_q == 2'd3) ? (sync2_q ^ prev_q) : '0;
    assign trig   = enable_i && (duration_i != '0) && (|change);

    // Lowest set change bit wins; scanning downwards lets the lowest overwrite.
    always_comb begin
        trig_idx = '0;
        trig_hp  = '0;
        for (int i = N_EVENTS - 1; i >= 0; i--) begin
            if (change[i]) begin
                trig_idx = IDX_W'(i);
                trig_hp  = half_period_i[i*DIV_W +: DIV_W];
            end
        end
    end

    // Duration compare is done one bit wider so a live-lowered duration still ends play.
    assign dur_p1  = {1'b0, dur_q} + (DUR_W + 1)'(1);
    assign dur_end = dur_p1 >= {1'b0, duration_i};
    assign dur_inc = dur_p1[DUR_W-1:0];

    // Square-wave step: toggle every hp_q cycles, silent when hp_q is zero.
    always_comb begin
        tone_nxt = tone_q + DIV_W'(1);
        spk_nxt  = spk_q;
        if (hp_q == '0) begin
            tone_nxt = '0;
            spk_nxt  = 1'b0;
        end else if (tone_q == hp_q - DIV_W'(1)) begin
            tone_nxt = '0;
            spk_nxt  = ~spk_q;
        end
    end

    // Next-state logic: enable abort, then (re)trigger, then per-state sequencing.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        spk_d   = spk_q;
        idx_d   = idx_q;
        if (!enable_i) begin
            state_d = StIdle;
            spk_d   = 1'b0;
            tone_d  = '0;
            dur_d   = '0;
        end else if (trig) begin
            state_d = StPlay;
            idx_d   = trig_idx;
            hp_d    = trig_hp;
            tone_d  = '0;
            dur_d   = '0;
            spk_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    spk_d = 1'b0;
                end
                StPlay: begin
                    if (dur_end) begin
`ifdef SOUND_DOUBLE_BEEP_EN
                        state_d = StGap;
`else
                        state_d = StIdle;
`endif
                        spk_d   = 1'b0;
                        tone_d  = '0;
                        dur_d   = '0;
                    end else begin
                        dur_d  = dur_inc;
                        tone_d = tone_nxt;
                        spk_d  = spk_nxt;
                    end
                end
`ifdef SOUND_DOUBLE_BEEP_EN
                StGap: begin
                    spk_d  = 1'b0;
                    tone_d = '0;
                    if (dur_end) begin
                        state_d = StPlay2;
                        dur_d   = '0;
                    end else begin
                        dur_d = dur_inc;
                    end
                end
                StPlay2: begin
                    if (dur_end) begin
                        state_d = StIdle;
                        spk_d   = 1'b0;
                        tone_d  = '0;
                        dur_d   = '0;
                    end else begin
                        dur_d  = dur_inc;
                        tone_d = tone_nxt;
                        spk_d  = spk_nxt;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Playback state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hp_q    <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            spk_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            spk_q   <= spk_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign speaker_o   = spk_q;
    assign active_ev_o = idx_q;

endmodule

// File: tb/tb_event_tone_player.sv
// Randomised scoreboard bench for event_tone_player with a time-since-trigger model.
module tb_event_tone_player;
    localparam int N    = 4;
    localparam int DW   = 18;
    localparam int DURW = 27;
    localparam int IW   = 4;
`ifdef SOUND_DOUBLE_BEEP_EN
    localparam int MULT = 3;
`else
    localparam int MULT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              enable_i;
    logic [N-1:0]      ev_level_i;
    logic [N*DW-1:0]   half_period_i;
    logic [DURW-1:0]   duration_i;
    logic              speaker_o;
    logic              busy_o;
    logic [IW-1:0]     active_ev_o;

    event_tone_player #(
        .N_EVENTS (N),
        .DIV_W    (DW),
        .DUR_W    (DURW),
        .IDX_W    (IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .ev_level_i    (ev_level_i),
        .half_period_i (half_period_i),
        .duration_i    (duration_i),
        .speaker_o     (speaker_o),
        .busy_o        (busy_o),
        .active_ev_o   (active_ev_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       spk;
        logic [3:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stimulus state.
    logic [3:0] lv;
    logic       en;
    int         dur;
    int         hp_tab[N];

    // Model: edges since reset release, level history, current play.
    int         m_n;
    logic [3:0] l1, l2, l3;
    bit         m_play;
    int         m_start;
    int         m_hp;
    int         m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tone_at(input int t, input int hp);
        if (hp == 0) return 1'b0;
        return ((t / hp) % 2) == 1;
    endfunction

    function automatic int lowest(input logic [3:0] c);
        for (int i = 0; i < N; i++) if (c[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_n = 0; l1 = '0; l2 = '0; l3 = '0;
        m_play = 0; m_start = 0; m_hp = 0; m_idx = 0;
    endtask

    // Drive one cycle's inputs, predict the output after the coming edge, push it.
    task automatic step();
        logic [3:0] chg;
        int         t;
        exp_t       e;
        ev_level_i = lv;
        enable_i   = en;
        duration_i = DURW'(dur);
        for (int i = 0; i < N; i++) half_period_i[i*DW +: DW] = DW'(hp_tab[i]);
        m_n++;
        chg = (m_n > 3) ? (l2 ^ l3) : 4'b0;
        l3 = l2; l2 = l1; l1 = lv;
        if (!en) begin
            m_play = 0;
        end else if (dur != 0 && chg != 0) begin
            m_play  = 1;
            m_start = m_n;
            m_idx   = lowest(chg);
            m_hp    = hp_tab[m_idx];
        end else if (m_play && (m_n - m_start) >= dur * MULT) begin
            m_play = 0;
        end
        t = m_n - m_start;
        e.busy = m_play;
        e.idx  = 4'(m_idx);
        e.spk  = 1'b0;
        if (m_play) begin
            if (t < dur) e.spk = tone_at(t, m_hp);
            else if (t >= 2 * dur) e.spk = tone_at(t - 2 * dur, m_hp);
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Apply reset from a negedge; returns at the negedge where rst_n rises.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_spk", 32'(speaker_o), 32'd0);
        chk("rst_idx", 32'(active_ev_o), 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued prediction after each edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("busy", 32'(busy_o), 32'(e.busy));
            chk("speaker", 32'(speaker_o), 32'(e.spk));
            chk("active_ev", 32'(active_ev_o), 32'(e.idx));
        end
    end

    initial begin
        lv  = 4'b0001;
        en  = 1'b1;
        dur = 20;
        hp_tab[0] = 5; hp_tab[1] = 4; hp_tab[2] = 3; hp_tab[3] = 2;
        rst_n         = 1'b0;
        ev_level_i    = lv;
        enable_i      = en;
        duration_i    = DURW'(dur);
        half_period_i = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Level high through reset release must not trigger.
        run(50);
        // Single event, hp=3.
        lv[2] = 1'b1; run(10 + 20 * MULT);
        // Simultaneous toggles: lowest index wins.
        lv[1] = ~lv[1]; lv[3] = ~lv[3]; run(10 + 20 * MULT);
        // Retrigger at play cycle 10 with event 0.
        lv[2] = ~lv[2]; run(10);
        lv[0] = ~lv[0]; run(10 + 20 * MULT);
        // Enable dropped at play cycle 7, toggle while disabled, zero duration.
        lv[2] = ~lv[2]; run(9);
        en = 1'b0; run(3);
        lv[1] = ~lv[1]; run(6);
        en = 1'b1; run(6);
        dur = 0; lv[3] = ~lv[3]; run(6);
        dur = 20;
        // Silent event still runs the full duration.
        hp_tab[3] = 0; lv[3] = ~lv[3]; run(5 + 20 * MULT);
        hp_tab[3] = 2;
`ifndef SOUND_DOUBLE_BEEP_EN
        // Duration lowered below the elapsed count mid-play.
        lv[0] = ~lv[0]; run(12);
        dur = 5; run(3);
        dur = 20; run(5);
`endif
        // Double beep check with hp=2, duration=8.
        dur = 8; hp_tab[1] = 2; lv[1] = ~lv[1]; run(8 + 8 * MULT);
        // Mid-play asynchronous reset.
        dur = 20; lv[2] = ~lv[2]; run(8);
        #2;
        do_reset();
        run(20);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 7) == 0) lv = lv ^ 4'($urandom_range(1, 15));
                else lv[$urandom_range(0, 3)] = ~lv[$urandom_range(0, 3)];
            end
            if ($urandom_range(0, 15) == 0) hp_tab[$urandom_range(0, 3)] = $urandom_range(0, 6);
            if ((MULT == 1 || !m_play) && $urandom_range(0, 19) == 0) dur = $urandom_range(0, 30);
            if (en && $urandom_range(0, 99) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            step();
        end

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
